// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM run sequencer: state encoding, width/limit
// defaults and the reference clamp helper.
package pwm_pkg;

  // Run-state encoding, also driven out on the 3-bit state port.
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StArm   = 3'd1,
    StRun   = 3'd2,
    StDrain = 3'd3,
    StFault = 3'd4
  } pwm_state_e;

  localparam int unsigned CntWDefault     = 16;
  localparam int unsigned ModWDefault     = 16;
  localparam int unsigned ModLimitDefault = 30000;

  // Clamp a signed reference into [-lim, +lim]; lim must be positive.
  function automatic int clamp_ref(input int val, input int lim);
    if (val > lim) begin
      return lim;
    end else if (val < -lim) begin
      return -lim;
    end
    return val;
  endfunction

endpackage

// File: rtl/pwm_ref_buffer.sv
// Modulation reference double buffer: one pending entry with clamp and
// valid/ready acceptance, plus the live mod_out register.
// Optional PWM_SOFT_START_EN: a target register is loaded at update points
// and mod_out slews toward it by at most RAMP_STEP per update point.
module pwm_ref_buffer
  import pwm_pkg::*;
#(
  parameter int unsigned MOD_W     = ModWDefault,
  parameter int unsigned MOD_LIMIT = ModLimitDefault,
  parameter int unsigned RAMP_STEP = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [MOD_W-1:0] mod_in,
  input  logic                    mod_valid,
  input  logic                    block,      // refuse new references (fault state)
  input  logic                    clr,        // drop pending, force output to 0
  input  logic                    zero,       // force output to 0, pending kept
  input  logic                    entry,      // ARM -> RUN edge
  input  logic                    upd,        // update point while running
  input  logic                    drain_upd,  // update point while draining
  output logic                    mod_ready,
  output logic signed [MOD_W-1:0] mod_out
);

  logic signed [MOD_W-1:0] pend_q, pend_d;
  logic                    full_q, full_d;
  logic signed [MOD_W-1:0] mod_q, mod_d;
  logic signed [MOD_W-1:0] clamped;
  logic                    accept;

  assign mod_ready = ~full_q & ~block;
  assign accept    = mod_valid & mod_ready;
  assign clamped   = MOD_W'(clamp_ref(int'(mod_in), int'(MOD_LIMIT)));
  assign mod_out   = mod_q;

`ifdef PWM_SOFT_START_EN
  localparam int Step = int'(RAMP_STEP);

  logic signed [MOD_W-1:0] tgt_q, tgt_d;
  logic signed [MOD_W-1:0] tgt_n;

  function automatic int step_toward(input int cur, input int tgt);
    int diff;
    diff = tgt - cur;
    if (diff > Step) begin
      return cur + Step;
    end else if (diff < -Step) begin
      return cur - Step;
    end
    return tgt;
  endfunction

  // Next-state for pending, target and ramped output.
  always_comb begin
    pend_d = pend_q;
    full_d = full_q;
    mod_d  = mod_q;
    tgt_d  = tgt_q;
    tgt_n  = full_q ? pend_q : tgt_q;
    if (clr) begin
      pend_d = '0;
      full_d = 1'b0;
      mod_d  = '0;
      tgt_d  = '0;
    end else begin
      // Accept needs an empty slot, so it never races a consume below.
      if (accept) begin
        pend_d = clamped;
        full_d = 1'b1;
      end
      if (zero) begin
        mod_d = '0;
        tgt_d = '0;
      end else if (entry) begin
        mod_d = '0;
        tgt_d = full_q ? pend_q : '0;
        if (full_q) full_d = 1'b0;
      end else if (upd) begin
        tgt_d = tgt_n;
        mod_d = MOD_W'(step_toward(int'(mod_q), int'(tgt_n)));
        if (full_q) full_d = 1'b0;
      end else if (drain_upd) begin
        mod_d = MOD_W'(step_toward(int'(mod_q), 0));
      end
    end
  end

  // Target register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tgt_q <= '0;
    else     tgt_q <= tgt_d;
  end
`else
  localparam int unsigned unused_ramp_step = RAMP_STEP;
  logic unused_drain;
  assign unused_drain = drain_upd;

  // Next-state for pending and directly loaded output.
  always_comb begin
    pend_d = pend_q;
    full_d = full_q;
    mod_d  = mod_q;
    if (clr) begin
      pend_d = '0;
      full_d = 1'b0;
      mod_d  = '0;
    end else begin
      // Accept needs an empty slot, so it never races a consume below.
      if (accept) begin
        pend_d = clamped;
        full_d = 1'b1;
      end
      if (zero) begin
        mod_d = '0;
      end else if (entry) begin
        mod_d = full_q ? pend_q : '0;
        if (full_q) full_d = 1'b0;
      end else if (upd && full_q) begin
        mod_d  = pend_q;
        full_d = 1'b0;
      end
    end
  end
`endif

  // Pending entry and live output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      full_q <= 1'b0;
      mod_q  <= '0;
    end else begin
      pend_q <= pend_d;
      full_q <= full_d;
      mod_q  <= mod_d;
    end
  end

endmodule

// File: rtl/pwm_run_sequencer.sv
// Run controller for the 3-level phase-shifted modulator: free-running carrier
// address counter, start/stop/fault sequencing of the bridge gate enable, and
// period-aligned hand-over of the modulation reference.
// Optional feature macro: PWM_SOFT_START_EN (ramped reference, see pwm_ref_buffer).
module pwm_run_sequencer
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W     = CntWDefault,
  parameter int unsigned MOD_W     = ModWDefault,
  parameter int unsigned MOD_LIMIT = ModLimitDefault,
  parameter int unsigned UPD_HALF  = 1,
  parameter int unsigned RAMP_STEP = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    fault,
  input  logic                    fault_clr,
  input  logic signed [MOD_W-1:0] mod_in,
  input  logic                    mod_valid,
  output logic                    mod_ready,
  output logic [CNT_W-1:0]        cnt_addr,
  output logic signed [MOD_W-1:0] mod_out,
  output logic                    gate_en,
  output logic                    period_start,
  output logic [2:0]              state
);

  localparam logic [CNT_W-1:0] CntMax   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] HalfLast = {1'b0, {(CNT_W-1){1'b1}}};

  pwm_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q, run_d;
  logic             wrap, half, upd_pt;
  logic             op_clr, op_zero, op_entry, op_upd, op_drain;

  // The edge leaving the current count is a wrap/half edge.
  assign wrap   = (cnt_q == CntMax);
  assign half   = (cnt_q == HalfLast);
  assign upd_pt = wrap | (half & (UPD_HALF != 0));

  // Carrier counter runs in every state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_q + CNT_W'(1);
  end

  // Next-state logic: fault beats stop beats start.
  always_comb begin
    state_d = state_q;
    if (fault) begin
      state_d = StFault;
    end else begin
      unique case (state_q)
        StIdle:  if (start && !stop) state_d = StArm;
        StArm: begin
          if (stop)      state_d = StIdle;
          else if (wrap) state_d = StRun;
        end
        StRun:   if (stop) state_d = StDrain;
        StDrain: if (wrap) state_d = StIdle;
        StFault: if (fault_clr) state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
    run_d = (state_d == StRun) || (state_d == StDrain);
  end

  // State and run-flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  // Reference buffer commands decoded from the current state and edge type.
  always_comb begin
    op_clr   = fault || (state_q == StFault);
    op_zero  = (state_q == StIdle) || ((state_q == StDrain) && wrap);
    op_entry = (state_q == StArm) && wrap && !stop;
    op_upd   = (state_q == StRun) && upd_pt;
    op_drain = (state_q == StDrain) && upd_pt;
  end

  pwm_ref_buffer #(
    .MOD_W     (MOD_W),
    .MOD_LIMIT (MOD_LIMIT),
    .RAMP_STEP (RAMP_STEP)
  ) u_ref_buffer (
    .clk       (clk),
    .rst       (rst),
    .mod_in    (mod_in),
    .mod_valid (mod_valid),
    .block     (state_q == StFault),
    .clr       (op_clr),
    .zero      (op_zero),
    .entry     (op_entry),
    .upd       (op_upd),
    .drain_upd (op_drain),
    .mod_ready (mod_ready),
    .mod_out   (mod_out)
  );

  // Gate drops combinationally with fault, ahead of the state change.
  assign gate_en      = run_q & ~fault;
  assign period_start = (state_q == StRun) && (cnt_q == '0);
  assign cnt_addr     = cnt_q;
  assign state        = state_q;

endmodule

// File: tb/tb_pwm_run_sequencer.sv
// Directed bench for pwm_run_sequencer with a shortened carrier (CNT_W=8:
// wrap 255->0, half edge 127->128). Inputs change and outputs are sampled
// on the falling clock edge.
module tb_pwm_run_sequencer;

  localparam int unsigned CntW = 8;
  localparam int unsigned ModW = 16;
`ifdef PWM_SOFT_START_EN
  localparam bit Soft = 1'b1;
`else
  localparam bit Soft = 1'b0;
`endif

  logic                   clk, rst, start, stop, fault, fault_clr, mod_valid;
  logic signed [ModW-1:0] mod_in;
  logic                   mod_ready, gate_en, period_start;
  logic [CntW-1:0]        cnt_addr;
  logic signed [ModW-1:0] mod_out;
  logic [2:0]             state;

  int total = 0;
  int bad   = 0;

  pwm_run_sequencer #(
    .CNT_W     (CntW),
    .MOD_W     (ModW),
    .MOD_LIMIT (30000),
    .UPD_HALF  (1),
    .RAMP_STEP (64)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .fault        (fault),
    .fault_clr    (fault_clr),
    .mod_in       (mod_in),
    .mod_valid    (mod_valid),
    .mod_ready    (mod_ready),
    .cnt_addr     (cnt_addr),
    .mod_out      (mod_out),
    .gate_en      (gate_en),
    .period_start (period_start),
    .state        (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Advance falling edges until cnt_addr equals target, bounded.
  task automatic wait_cnt(input int target);
    int n;
    n = 0;
    while (int'(cnt_addr) != target && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (n >= 600) check("wait_cnt_timeout", int'(cnt_addr), target);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; fault = 1'b0; fault_clr = 1'b0;
    mod_valid = 1'b0; mod_in = '0;
    step(); step(); step();
    check("rst_cnt", int'(cnt_addr), 0);
    check("rst_mod_out", int'(mod_out), 0);
    check("rst_gate", int'(gate_en), 0);
    check("rst_pstart", int'(period_start), 0);
    check("rst_state", int'(state), 0);
    check("rst_ready", int'(mod_ready), 1);
    rst = 1'b0;

    // Start mid-period: ARM until the wrap edge.
    wait_cnt(100);
    start = 1'b1;
    step();
    check("arm_state", int'(state), 1);
    check("arm_gate", int'(gate_en), 0);
    start = 1'b0;
    wait_cnt(255);
    check("arm_hold_state", int'(state), 1);
    check("arm_hold_gate", int'(gate_en), 0);
    step();
    check("run_cnt", int'(cnt_addr), 0);
    check("run_state", int'(state), 2);
    check("run_gate", int'(gate_en), 1);
    check("run_pstart", int'(period_start), 1);
    check("run_mod_out0", int'(mod_out), 0);
    step();
    check("pstart_one_cycle", int'(period_start), 0);

    // Accept 12000 at cnt 5; lands on the half edge.
    wait_cnt(5);
    check("ready_before", int'(mod_ready), 1);
    mod_in = 16'sd12000;
    mod_valid = 1'b1;
    step();
    mod_valid = 1'b0;
    check("ready_after_acc", int'(mod_ready), 0);
    check("mod_old_after_acc", int'(mod_out), 0);
    wait_cnt(127);
    check("mod_old_pre_half", int'(mod_out), 0);
    check("ready_pre_half", int'(mod_ready), 0);
    step();
    check("mod_half", int'(mod_out), Soft ? 64 : 12000);
    check("ready_half", int'(mod_ready), 1);

    // Out-of-range reference is clamped to -30000.
    mod_in = -16'sd32000;
    mod_valid = 1'b1;
    step();
    mod_valid = 1'b0;
    wait_cnt(255);
    check("mod_pre_wrap", int'(mod_out), Soft ? 64 : 12000);
    step();
    check("mod_clamped", int'(mod_out), Soft ? 0 : -30000);
    check("pstart_2nd", int'(period_start), 1);

    // Stop at cnt 200: DRAIN keeps the gate until the wrap edge.
    wait_cnt(200);
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("drain_state", int'(state), 3);
    check("drain_gate", int'(gate_en), 1);
    mod_in = 16'sd300;
    mod_valid = 1'b1;
    step();
    mod_valid = 1'b0;
    wait_cnt(255);
    check("drain_hold_state", int'(state), 3);
    check("drain_hold_gate", int'(gate_en), 1);
    check("drain_mod", int'(mod_out), Soft ? -64 : -30000);
    step();
    check("drain_exit_state", int'(state), 0);
    check("drain_exit_gate", int'(gate_en), 0);
    check("drain_exit_mod", int'(mod_out), 0);
    check("pending_held", int'(mod_ready), 0);

    // Start+stop together in IDLE: no move.
    start = 1'b1;
    stop = 1'b1;
    step();
    check("start_stop_idle", int'(state), 0);
    stop = 1'b0;
    step();
    check("rearm_state", int'(state), 1);
    start = 1'b0;
    wait_cnt(0);
    check("rerun_state", int'(state), 2);
    check("rerun_mod", int'(mod_out), Soft ? 0 : 300);
    check("rerun_ready", int'(mod_ready), 1);
`ifdef PWM_SOFT_START_EN
    // Ramp 0 -> 300 in steps of 64 at successive update points.
    wait_cnt(128);
    check("ramp_1", int'(mod_out), 64);
    wait_cnt(0);
    check("ramp_2", int'(mod_out), 128);
    wait_cnt(128);
    check("ramp_3", int'(mod_out), 192);
    wait_cnt(0);
    check("ramp_4", int'(mod_out), 256);
    wait_cnt(128);
    check("ramp_5", int'(mod_out), 300);
`else
    wait_cnt(128);
    check("hold_no_pending", int'(mod_out), 300);
`endif

    // Fault: gate drops at once, FAULT on the next edge.
    wait_cnt(37);
    fault = 1'b1;
    #1;
    check("fault_gate_now", int'(gate_en), 0);
    check("fault_state_now", int'(state), 2);
    @(negedge clk);
    check("fault_state", int'(state), 4);
    check("fault_ready", int'(mod_ready), 0);
    check("fault_mod", int'(mod_out), 0);
    fault_clr = 1'b1;
    step();
    check("fault_clr_blocked", int'(state), 4);
    fault = 1'b0;
    step();
    check("fault_cleared", int'(state), 0);
    check("fault_cleared_ready", int'(mod_ready), 1);
    fault_clr = 1'b0;

    // Asynchronous reset in the middle of RUN.
    start = 1'b1;
    step();
    start = 1'b0;
    wait_cnt(0);
    check("run3_state", int'(state), 2);
    wait_cnt(10);
    rst = 1'b1;
    #1;
    check("arst_state", int'(state), 0);
    check("arst_cnt", int'(cnt_addr), 0);
    check("arst_gate", int'(gate_en), 0);
    check("arst_mod", int'(mod_out), 0);
    step();
    rst = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
